// File: rtl/vn_multi_packer.sv
// Multi-channel Von Neumann debiaser: pairs raw bits per channel and packs survivors LSB-first into words.
// Optional statistics outputs (stat_pairs, stat_bits) exist only when VN_STATS_EN is defined.
module vn_multi_packer #(
  parameter int N_CH  = 4,
  parameter int OUT_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_CH-1:0]  raw_bit,
  input  logic [N_CH-1:0]  raw_valid,
  output logic [OUT_W-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             drop_sticky
`ifdef VN_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_pairs,
  output logic [CNT_W-1:0] stat_bits
`endif
);

  localparam int ACC_W = OUT_W + N_CH;
  localparam int CW    = $clog2(ACC_W + 1);
  localparam int KW    = $clog2(N_CH + 1);
  localparam logic [CW-1:0] OUT_W_C = CW'(OUT_W);
  localparam logic [CW:0]   ACC_W_C = (CW + 1)'(ACC_W);

  if (N_CH < 1 || N_CH > 8 || OUT_W < N_CH || (OUT_W % 8) != 0 || CNT_W < 1) begin : g_bad_param
    $error("vn_multi_packer: illegal parameter combination");
  end

  typedef enum logic {IDLE = 1'b0, HAVE_FIRST = 1'b1} pair_st_t;

  pair_st_t        st_q [N_CH];
  logic [N_CH-1:0] first_q;
  logic [N_CH-1:0] vb_q;
  logic [N_CH-1:0] vv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) st_q[c] <= IDLE;
      first_q <= '0;
      vb_q    <= '0;
      vv_q    <= '0;
    end else begin
      vv_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        if (!enable) begin
          st_q[c] <= IDLE;
        end else if (raw_valid[c]) begin
          case (st_q[c])
            IDLE: begin
              first_q[c] <= raw_bit[c];
              st_q[c]    <= HAVE_FIRST;
            end
            HAVE_FIRST: begin
              st_q[c] <= IDLE;
              // 01 -> 0, 10 -> 1: the surviving bit is the first of the pair
              if (first_q[c] != raw_bit[c]) begin
                vb_q[c] <= first_q[c];
                vv_q[c] <= 1'b1;
              end
            end
            default: st_q[c] <= IDLE;
          endcase
        end
      end
    end
  end

  logic [ACC_W-1:0] acc_q, acc_d, acc_t;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_t;
  logic [OUT_W-1:0] word_q;
  logic             wvld_q;
  logic             drop_q;
  logic [N_CH-1:0]  cbits;
  logic [KW-1:0]    k;
  logic             xfer;
  logic             fit;
  logic             drop;

  always_comb begin
    cbits = '0;
    k     = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (vv_q[c]) begin
        cbits = cbits | (N_CH'(vb_q[c]) << k);
        k     = k + KW'(1);
      end
    end

    xfer  = (cnt_q >= OUT_W_C) && (!wvld_q || word_ready);
    acc_t = xfer ? (acc_q >> OUT_W) : acc_q;
    cnt_t = xfer ? (cnt_q - OUT_W_C) : cnt_q;
    // Appends see the post-transfer fill level; an overflowing group is dropped whole
    fit   = ({1'b0, cnt_t} + (CW + 1)'(k)) <= ACC_W_C;

    acc_d = acc_t;
    cnt_d = cnt_t;
    drop  = 1'b0;
    if (k != '0) begin
      if (fit) begin
        acc_d = acc_t | (ACC_W'(cbits) << cnt_t);
        cnt_d = cnt_t + CW'(k);
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      wvld_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (xfer) begin
        word_q <= acc_q[OUT_W-1:0];
        wvld_q <= 1'b1;
      end else if (wvld_q && word_ready) begin
        wvld_q <= 1'b0;
      end
      if (drop) drop_q <= 1'b1;
    end
  end

  assign word_out    = word_q;
  assign word_valid  = wvld_q;
  assign drop_sticky = drop_q;

`ifdef VN_STATS_EN
  logic [KW-1:0]    npairs;
  logic [CNT_W-1:0] stat_pairs_q, stat_pairs_d;
  logic [CNT_W-1:0] stat_bits_q, stat_bits_d;
  logic [CNT_W:0]   pairs_sum, bits_sum;

  always_comb begin
    npairs = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (enable && raw_valid[c] && st_q[c] == HAVE_FIRST) npairs = npairs + KW'(1);
    end
    pairs_sum    = {1'b0, stat_pairs_q} + (CNT_W + 1)'(npairs);
    bits_sum     = {1'b0, stat_bits_q} + (CNT_W + 1)'(fit ? k : '0);
    stat_pairs_d = pairs_sum[CNT_W] ? '1 : pairs_sum[CNT_W-1:0];
    stat_bits_d  = bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pairs_q <= '0;
      stat_bits_q  <= '0;
    end else begin
      stat_pairs_q <= stat_pairs_d;
      stat_bits_q  <= stat_bits_d;
    end
  end

  assign stat_pairs = stat_pairs_q;
  assign stat_bits  = stat_bits_q;
`endif

endmodule
